// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: state encodings,
// default timeout, byte-enable patterns and the captured request payload.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_TIMEOUT = 15;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned DW          = 32;
    localparam int unsigned BEW         = 4;

    localparam logic [BEW-1:0] BE_WORD    = 4'hF;
    localparam logic [BEW-1:0] BE_HALF_LO = 4'h3;
    localparam logic [BEW-1:0] BE_HALF_HI = 4'hC;

    typedef struct packed {
        logic           we;
        logic [BEW-1:0] be;
        logic [DW-1:0]  wdata;
    } mem_wr_t;

    // Word accesses need a word-aligned address, halfword accesses an even one.
    function automatic logic d_misaligned(input logic [1:0] lsb, input logic [BEW-1:0] be);
        logic mis;
        mis = 1'b0;
        if (be == BE_WORD) begin
            mis = (lsb != 2'b00);
        end else if ((be == BE_HALF_LO) || (be == BE_HALF_HI)) begin
            mis = lsb[0];
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles; expired is high on the LIMIT-th consecutive enabled cycle.
module mem_timeout_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = enable && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto a single memory port,
// one transaction outstanding, with alternating priority and a BUSY timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned AW      = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_req,
    input  logic [AW-1:0]  if_addr,
    output logic           if_gnt,
    output logic           if_rvalid,
    output logic [DW-1:0]  if_rdata,
    output logic           if_err,
    input  logic           d_req,
    input  logic           d_we,
    input  logic [AW-1:0]  d_addr,
    input  logic [DW-1:0]  d_wdata,
    input  logic [BEW-1:0] d_be,
    output logic           d_gnt,
    output logic           d_rvalid,
    output logic [DW-1:0]  d_rdata,
    output logic           d_err,
    output logic           m_req,
    output logic           m_we,
    output logic [AW-1:0]  m_addr,
    output logic [DW-1:0]  m_wdata,
    output logic [BEW-1:0] m_be,
    input  logic           m_ack,
    input  logic [DW-1:0]  m_rdata,
    output logic           stall
);

    arb_state_e state;
    logic       last_d;
    logic       if_elig, d_elig, pick_d;
    logic       if_mis, d_mis;
    logic       busy, expired, done;
    mem_wr_t    d_cmd, i_cmd;

    // A source is not re-eligible while its own response is on the bus.
    assign if_elig = if_req & ~if_rvalid;
    assign d_elig  = d_req & ~d_rvalid;
    assign pick_d  = d_elig & (~if_elig | ~last_d);
    assign if_mis  = (if_addr[1:0] != 2'b00);
    assign d_mis   = d_misaligned(d_addr[1:0], d_be);
    assign busy    = (state != ST_IDLE);
    assign done    = m_ack | expired;
    assign stall   = busy | if_elig | d_req;

    assign d_cmd = '{we: d_we, be: d_be, wdata: d_wdata};
    assign i_cmd = '{we: 1'b0, be: BE_WORD, wdata: '0};

    mem_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (~busy),
        .enable  (busy),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_d    <= 1'b0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_be      <= '0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_err    <= 1'b0;
            d_err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_d) begin
                        last_d <= 1'b1;
                        if (d_mis) begin
                            d_rvalid <= 1'b1;
                            d_err    <= 1'b1;
                            d_rdata  <= '0;
                        end else begin
                            state   <= ST_BUSY_D;
                            d_gnt   <= 1'b1;
                            m_req   <= 1'b1;
                            m_addr  <= d_addr;
                            m_we    <= d_cmd.we;
                            m_be    <= d_cmd.be;
                            m_wdata <= d_cmd.wdata;
                        end
                    end else if (if_elig) begin
                        last_d <= 1'b0;
                        if (if_mis) begin
                            if_rvalid <= 1'b1;
                            if_err    <= 1'b1;
                            if_rdata  <= '0;
                        end else begin
                            state   <= ST_BUSY_I;
                            if_gnt  <= 1'b1;
                            m_req   <= 1'b1;
                            m_addr  <= if_addr;
                            m_we    <= i_cmd.we;
                            m_be    <= i_cmd.be;
                            m_wdata <= i_cmd.wdata;
                        end
                    end
                end
                ST_BUSY_I: begin
                    if (done) begin
                        state     <= ST_IDLE;
                        m_req     <= 1'b0;
                        if_rvalid <= 1'b1;
                        if_err    <= ~m_ack;
                        if_rdata  <= m_ack ? m_rdata : '0;
                    end
                end
                ST_BUSY_D: begin
                    if (done) begin
                        state    <= ST_IDLE;
                        m_req    <= 1'b0;
                        d_rvalid <= 1'b1;
                        d_err    <= ~m_ack;
                        d_rdata  <= m_ack ? m_rdata : '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 15;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid, if_err;
    logic [31:0]   if_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_be;
    logic          d_gnt, d_rvalid, d_err;
    logic [31:0]   d_rdata;
    logic          m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_be;
    logic          m_ack;
    logic [31:0]   m_rdata;
    logic          stall;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TO), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ack(m_ack), .m_rdata(m_rdata), .stall(stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = 4'hF;
        m_ack = 1'b0; m_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; m_ack = 1'b1; m_rdata = 32'hFFFFFFFF;
        tick(); tick();
        total++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, m_req, m_we} !== 8'h00) $display("FAIL reset_ctrl: got %b want 00000000", {if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, m_req, m_we}); else passed++;
        total++; if ({if_rdata, d_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata}); else passed++;
        total++; if ({m_addr, m_wdata, m_be} !== 68'h0) $display("FAIL reset_mbus: got %h want 0", {m_addr, m_wdata, m_be}); else passed++;
        rst = 1'b0;
        idle_inputs();
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        total++; if ({m_req, if_rvalid, d_rvalid, stall} !== 4'b0000) $display("FAIL reset_idle_ack: got %b want 0000", {m_req, if_rvalid, d_rvalid, stall}); else passed++;
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h00000010;
        tick();
        total++; if ({if_gnt, d_gnt, m_req, m_we, m_be} !== 8'b1010_1111) $display("FAIL fetch_grant: got %b want 10101111", {if_gnt, d_gnt, m_req, m_we, m_be}); else passed++;
        total++; if (m_addr !== 32'h10) $display("FAIL fetch_addr: got %h want 00000010", m_addr); else passed++;
        total++; if (stall !== 1'b1) $display("FAIL fetch_stall_busy: got %b want 1", stall); else passed++;
        tick();
        total++; if ({if_gnt, m_req, if_rvalid} !== 3'b010) $display("FAIL fetch_gnt_once: got %b want 010", {if_gnt, m_req, if_rvalid}); else passed++;
        tick();
        m_ack = 1'b1; m_rdata = 32'h00500093;
        tick();
        m_ack = 1'b0; m_rdata = '0;
        total++; if ({if_rvalid, if_err, m_req, if_gnt} !== 4'b1000) $display("FAIL fetch_resp: got %b want 1000", {if_rvalid, if_err, m_req, if_gnt}); else passed++;
        total++; if (if_rdata !== 32'h00500093) $display("FAIL fetch_rdata: got %h want 00500093", if_rdata); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL fetch_stall_masked: got %b want 0", stall); else passed++;
        if_req = 1'b0;
        tick();
        total++; if ({stall, if_rvalid, m_req} !== 3'b000) $display("FAIL fetch_after: got %b want 000", {stall, if_rvalid, m_req}); else passed++;
        total++; if (if_rdata !== 32'h00500093) $display("FAIL fetch_rdata_hold: got %h want 00500093", if_rdata); else passed++;
    endtask

    task automatic test_contention();
        rst = 1'b1; tick(); rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF;
        tick();
        total++; if ({d_gnt, if_gnt, m_we} !== 3'b100) $display("FAIL cont_first_gnt: got %b want 100", {d_gnt, if_gnt, m_we}); else passed++;
        total++; if (m_addr !== 32'h40) $display("FAIL cont_first_addr: got %h want 00000040", m_addr); else passed++;
        m_ack = 1'b1; m_rdata = 32'h11111111;
        tick();
        m_ack = 1'b0; m_rdata = '0;
        total++; if ({d_rvalid, d_err, if_rvalid} !== 3'b100 || d_rdata !== 32'h11111111) $display("FAIL cont_d_resp: got %b/%h want 100/11111111", {d_rvalid, d_err, if_rvalid}, d_rdata); else passed++;
        d_req = 1'b0;
        tick();
        total++; if ({if_gnt, d_gnt} !== 2'b10 || m_addr !== 32'h20) $display("FAIL cont_second: got %b/%h want 10/00000020", {if_gnt, d_gnt}, m_addr); else passed++;
        m_ack = 1'b1; m_rdata = 32'h22222222;
        tick();
        m_ack = 1'b0; m_rdata = '0;
        total++; if ({if_rvalid, if_err} !== 2'b10 || if_rdata !== 32'h22222222) $display("FAIL cont_i_resp: got %b/%h want 10/22222222", {if_rvalid, if_err}, if_rdata); else passed++;
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h104; d_be = 4'b0011; d_wdata = 32'hDEADBEEF;
        tick();
        total++; if (d_gnt !== 1'b1) $display("FAIL store_gnt: got %b want 1", d_gnt); else passed++;
        d_wdata = '0; d_addr = 32'h999; d_be = 4'hF; d_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if ({m_req, m_we, m_be, m_addr, m_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h104, 32'hDEADBEEF}) $display("FAIL store_hold%0d: got %b %b %h %h %h want 1 1 3 00000104 deadbeef", i, m_req, m_we, m_be, m_addr, m_wdata); else passed++;
            tick();
        end
        m_ack = 1'b1; m_rdata = 32'hCAFE0000;
        tick();
        m_ack = 1'b0; m_rdata = '0;
        total++; if ({d_rvalid, d_err, m_req} !== 3'b100 || d_rdata !== 32'hCAFE0000) $display("FAIL store_resp: got %b/%h want 100/cafe0000", {d_rvalid, d_err, m_req}, d_rdata); else passed++;
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
        tick();
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (!m_req) break;
            n++;
            tick();
        end
        total++; if (n !== TO) $display("FAIL timeout_cycles: got %0d want %0d", n, TO); else passed++;
        total++; if ({d_rvalid, d_err, m_req} !== 3'b110) $display("FAIL timeout_resp: got %b want 110", {d_rvalid, d_err, m_req}); else passed++;
        total++; if (d_rdata !== 32'h0) $display("FAIL timeout_rdata: got %h want 00000000", d_rdata); else passed++;
        d_req = 1'b0;
        tick();
        total++; if ({d_rvalid, d_err, m_req} !== 3'b000) $display("FAIL timeout_after: got %b want 000", {d_rvalid, d_err, m_req}); else passed++;
    endtask

    task automatic test_misalign();
        if_req = 1'b1; if_addr = 32'h00000002;
        tick();
        total++; if ({m_req, if_gnt, if_rvalid, if_err} !== 4'b0011) $display("FAIL mis_fetch: got %b want 0011", {m_req, if_gnt, if_rvalid, if_err}); else passed++;
        if_req = 1'b0;
        tick();
        total++; if ({m_req, if_rvalid} !== 2'b00) $display("FAIL mis_fetch_after: got %b want 00", {m_req, if_rvalid}); else passed++;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h101; d_be = 4'hF;
        tick();
        total++; if ({m_req, d_gnt, d_rvalid, d_err} !== 4'b0011) $display("FAIL mis_word: got %b want 0011", {m_req, d_gnt, d_rvalid, d_err}); else passed++;
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h103; d_be = 4'b0011;
        tick();
        total++; if ({m_req, d_gnt, d_rvalid, d_err} !== 4'b0011) $display("FAIL mis_half: got %b want 0011", {m_req, d_gnt, d_rvalid, d_err}); else passed++;
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout_edge();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h208; d_be = 4'hF;
        tick();
        for (int i = 1; i < TO; i++) tick();
        total++; if ({m_req, d_rvalid} !== 2'b10) $display("FAIL tedge_busy: got %b want 10", {m_req, d_rvalid}); else passed++;
        m_ack = 1'b1; m_rdata = 32'h77770001;
        tick();
        m_ack = 1'b0; m_rdata = '0;
        total++; if ({d_rvalid, d_err, m_req} !== 3'b100 || d_rdata !== 32'h77770001) $display("FAIL tedge_resp: got %b/%h want 100/77770001", {d_rvalid, d_err, m_req}, d_rdata); else passed++;
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h12345678; d_be = 4'hF;
        tick();
        total++; if (m_req !== 1'b1) $display("FAIL rmid_busy: got %b want 1", m_req); else passed++;
        tick();
        rst = 1'b1; d_req = 1'b0;
        tick();
        rst = 1'b0; m_ack = 1'b1; m_rdata = 32'h5555AAAA;
        total++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, m_req, m_we} !== 8'h00) $display("FAIL rmid_ctrl: got %b want 00000000", {if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, m_req, m_we}); else passed++;
        total++; if ({if_rdata, d_rdata} !== 64'h0 || {m_addr, m_wdata, m_be} !== 68'h0) $display("FAIL rmid_data: got %h %h want 0 0", {if_rdata, d_rdata}, {m_addr, m_wdata, m_be}); else passed++;
        tick();
        m_ack = 1'b0; m_rdata = '0;
        total++; if ({d_rvalid, if_rvalid, m_req, d_rdata} !== 35'h0) $display("FAIL rmid_late_ack: got %b %h want 000 0", {d_rvalid, if_rvalid, m_req}, d_rdata); else passed++;
        if_req = 1'b1; if_addr = 32'h44;
        tick();
        total++; if ({if_gnt, m_req} !== 2'b11 || m_addr !== 32'h44) $display("FAIL rmid_next_gnt: got %b/%h want 11/00000044", {if_gnt, m_req}, m_addr); else passed++;
        m_ack = 1'b1; m_rdata = 32'h00000013;
        tick();
        m_ack = 1'b0; m_rdata = '0;
        total++; if ({if_rvalid, if_err} !== 2'b10 || if_rdata !== 32'h13) $display("FAIL rmid_next_resp: got %b/%h want 10/00000013", {if_rvalid, if_err}, if_rdata); else passed++;
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_fetch();
        test_contention();
        test_store();
        test_timeout();
        test_misalign();
        test_timeout_edge();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
